// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// It runs a req/ack transaction with data memory for loads and stores.
// While a transaction is outstanding it stalls upstream through mem_stall_o.
// It aligns and sign-extends load data and builds store byte enables.
// It drives the MEM/WB register and the write-back forwarding value.
// Ports:
//   clk_i, rst_i (async, active-low), start_i             pipeline control
//   RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
//   RegAddr_i, WriteData_i, ALUdata_i                     EX/MEM register
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
//   mem_ack_i, mem_rdata_i                                memory handshake
//   mem_stall_o                                           upstream stall (comb)
//   RegWrite_o, MemToReg_o, RegAddr_o, MemData_o, ALUdata_o  MEM/WB register
//   WB_RegData_o                                          forwarding value (comb)
//   misalign_o, bus_err_o                                 one-cycle error pulses
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic [1:0]  MemRead_i,
    input  logic [1:0]  MemWrite_i,
    input  logic [4:0]  RegAddr_i,
    input  logic [31:0] WriteData_i,
    input  logic [31:0] ALUdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_stall_o,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic [4:0]  RegAddr_o,
    output logic [31:0] MemData_o,
    output logic [31:0] ALUdata_o,
    output logic [31:0] WB_RegData_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        off_q, size_q;
    logic              is_write, is_mem, misaligned, timeout;
    logic [1:0]        size, off;
    logic              issue, complete, bypass, wb_en;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;

    // Decode the EX/MEM access; a store wins over a simultaneous load
    assign is_write   = MemWrite_i != 2'd0;
    assign is_mem     = is_write || (MemRead_i != 2'd0);
    assign size       = is_write ? MemWrite_i : MemRead_i;
    assign off        = ALUdata_i[1:0];
    assign misaligned = ((size == 2'd2) && off[0]) || ((size == 2'd3) && (off != 2'd0));
    assign timeout    = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

    // Next state, stall and MEM/WB strobes
    always_comb begin
        state_d     = state_q;
        mem_stall_o = 1'b0;
        issue       = 1'b0;
        complete    = 1'b0;
        bypass      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (is_mem && !misaligned) begin
                        mem_stall_o = 1'b1;
                        issue       = 1'b1;
                        state_d     = REQ;
                    end else begin
                        bypass = 1'b1;
                    end
                end
            end
            REQ: begin
                // A timeout finishes the access just like an ack would
                if (mem_ack_i || timeout) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mem_stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_en = complete || bypass;

    // Store lane placement (enables also describe load width)
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = WriteData_i;
        case (size)
            2'd1: begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{WriteData_i[7:0]}};
            end
            2'd2: begin
                be_d    = off[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteData_i[15:0]}};
            end
            2'd3: be_d = 4'b1111;
            default: be_d = 4'b0000;
        endcase
    end

    // Load lane extraction from the offset captured at issue
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
            2'd2:    load_data = {{16{half_sel[15]}}, half_sel};
            2'd3:    load_data = mem_rdata_i;
            default: load_data = 32'd0;
        endcase
    end

    // FSM state, timeout counter and request fields
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
        end else begin
            state_q   <= state_d;
            mem_req_o <= state_d == REQ;
            if (issue) begin
                cnt_q       <= '0;
                mem_we_o    <= is_write;
                mem_addr_o  <= {ALUdata_i[31:2], 2'b00};
                mem_be_o    <= be_d;
                mem_wdata_o <= wdata_d;
                off_q       <= off;
                size_q      <= size;
            end else if (state_q == REQ && !complete) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // MEM/WB register and error pulses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_o <= 1'b0;
            MemToReg_o <= 1'b0;
            RegAddr_o  <= 5'd0;
            MemData_o  <= 32'd0;
            ALUdata_o  <= 32'd0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            misalign_o <= bypass && is_mem;
            bus_err_o  <= complete && !mem_ack_i;
            if (wb_en) begin
                // Misaligned or timed-out accesses must not write the register file
                RegWrite_o <= RegWrite_i && !(bypass && is_mem) && !(complete && !mem_ack_i);
                MemToReg_o <= MemToReg_i;
                RegAddr_o  <= RegAddr_i;
                ALUdata_o  <= ALUdata_i;
                MemData_o  <= (complete && mem_ack_i && !mem_we_o) ? load_data : 32'd0;
            end
        end
    end

    assign WB_RegData_o = MemToReg_o ? MemData_o : ALUdata_o;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// It uses a transaction-level reference model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        reg_write, mem_to_reg;
    logic [1:0]  mem_read, mem_write;
    logic [4:0]  reg_addr;
    logic [31:0] write_data, alu_data;
    logic        mem_req, mem_we, mem_ack, mem_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rw_o, mtr_o, misalign, bus_err;
    logic [4:0]  ra_o;
    logic [31:0] md_o, alu_o, wb_o;

    int n_checks = 0;
    int n_errors = 0;

    // Last expected MEM/WB contents
    logic        e_rw, e_mtr;
    logic [4:0]  e_ra;
    logic [31:0] e_alu, e_md;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .RegWrite_i(reg_write), .MemToReg_i(mem_to_reg),
        .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .RegAddr_i(reg_addr), .WriteData_i(write_data), .ALUdata_i(alu_data),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .mem_stall_o(mem_stall),
        .RegWrite_o(rw_o), .MemToReg_o(mtr_o), .RegAddr_o(ra_o),
        .MemData_o(md_o), .ALUdata_o(alu_o), .WB_RegData_o(wb_o),
        .misalign_o(misalign), .bus_err_o(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        start      = 1'b0;
        mem_read   = 2'd0;
        mem_write  = 2'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_ack    = 1'b0;
    endtask

    // One instruction through MEM; called just after a rising edge.
    // ack_cyc: REQ cycle number (1..) carrying the ack, 0 = never acked.
    task automatic run_op(input logic [1:0] rd, input logic [1:0] wr, input logic rw,
                          input logic mtr, input logic [4:0] ra, input logic [31:0] wd,
                          input logic [31:0] alu, input int ack_cyc, input logic [31:0] rdat);
        logic        is_mem, we, mis, tmo, done;
        logic [1:0]  sz, a;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, ld;
        int          exp_stalls, stalls, c;

        is_mem = (rd != 2'd0) || (wr != 2'd0);
        we     = wr != 2'd0;
        sz     = we ? wr : rd;
        a      = alu[1:0];
        mis    = is_mem && (((sz == 2'd2) && a[0]) || ((sz == 2'd3) && (a != 2'd0)));
        tmo    = is_mem && !mis && (ack_cyc == 0 || ack_cyc > TO);
        exp_be = 4'd0;
        exp_wd = wd;
        ld     = rdat;
        if (sz == 2'd1) begin
            exp_be = 4'(1 << a);
            exp_wd = {24'd0, wd[7:0]} * 32'h01010101;
            ld = (rdat >> (8 * a)) & 32'hFF;
            if (ld >= 32'd128) ld = ld - 32'd256;
        end else if (sz == 2'd2) begin
            exp_be = a[1] ? 4'b1100 : 4'b0011;
            exp_wd = {16'd0, wd[15:0]} * 32'h00010001;
            ld = (rdat >> (16 * a[1])) & 32'hFFFF;
            if (ld >= 32'd32768) ld = ld - 32'd65536;
        end else if (sz == 2'd3) begin
            exp_be = 4'b1111;
        end
        exp_stalls = (!is_mem || mis) ? 0 : (tmo ? TO : ack_cyc);
        e_rw  = rw && !mis && !tmo;
        e_mtr = mtr;
        e_ra  = ra;
        e_alu = alu;
        e_md  = (is_mem && !mis && !we && !tmo) ? ld : 32'd0;

        mem_read = rd; mem_write = wr; reg_write = rw; mem_to_reg = mtr;
        reg_addr = ra; write_data = wd; alu_data = alu;
        start = 1'b1; mem_ack = 1'b0; mem_rdata = $urandom;

        stalls = 0; c = 0; done = 1'b0;
        while (!done && c < 50) begin
            if (is_mem && !mis && c >= 1 && c == ack_cyc) begin
                mem_ack   = 1'b1;
                mem_rdata = rdat;
            end
            @(negedge clk);
            if (mem_stall) stalls++;
            if (c == 0) check("req_c0", 32'(mem_req), 32'd0);
            if (c >= 1 && is_mem && !mis) check("req_on", 32'(mem_req), 32'd1);
            if (c == 1 && is_mem && !mis) begin
                check("addr", mem_addr, {alu[31:2], 2'b00});
                check("be", 32'(mem_be), 32'(exp_be));
                check("we", 32'(mem_we), 32'(we));
                if (we) check("wdata", mem_wdata, exp_wd);
            end
            done = !mem_stall;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            c++;
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (!done) check("completion_bound", 32'd0, 32'd1);

        clear_inputs();
        @(negedge clk);
        check("req_after", 32'(mem_req), 32'd0);
        check("RegWrite", 32'(rw_o), 32'(e_rw));
        check("MemToReg", 32'(mtr_o), 32'(e_mtr));
        check("RegAddr", 32'(ra_o), 32'(e_ra));
        check("ALUdata", alu_o, e_alu);
        check("MemData", md_o, e_md);
        check("WB_RegData", wb_o, e_mtr ? e_md : e_alu);
        check("misalign_pulse", 32'(misalign), 32'(mis));
        check("bus_err_pulse", 32'(bus_err), 32'(tmo));
        @(posedge clk); #1;
        @(negedge clk);
        check("misalign_clear", 32'(misalign), 32'd0);
        check("bus_err_clear", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        reg_addr = 5'd0; write_data = 32'd0; alu_data = 32'd0; mem_rdata = 32'd0;
        #12;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_RegWrite", 32'(rw_o), 32'd0);
        check("rst_MemData", md_o, 32'd0);
        check("rst_ALUdata", alu_o, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(2'd3, 2'd0, 1'b1, 1'b1, 5'd8,  32'd0,        32'h100, 3, 32'hDEADBEEF);
        run_op(2'd0, 2'd1, 1'b0, 1'b0, 5'd0,  32'h000000A5, 32'h203, 1, 32'h12345678);
        run_op(2'd1, 2'd0, 1'b1, 1'b1, 5'd9,  32'd0,        32'h203, 2, 32'h80000000);
        run_op(2'd2, 2'd0, 1'b1, 1'b1, 5'd10, 32'd0,        32'h302, 1, 32'h7FFF0000);
        run_op(2'd3, 2'd0, 1'b1, 1'b1, 5'd11, 32'd0,        32'h101, 1, 32'h0);
        run_op(2'd0, 2'd0, 1'b1, 1'b0, 5'd12, 32'd0,        32'd5,   0, 32'h0);
        run_op(2'd3, 2'd0, 1'b1, 1'b1, 5'd13, 32'd0,        32'h400, 0, 32'h55555555);
        run_op(2'd2, 2'd3, 1'b1, 1'b0, 5'd14, 32'hCAFEF00D, 32'h404, 4, 32'h11111111);

        // start low: pending lw must not issue and MEM/WB holds
        mem_read = 2'd3; alu_data = 32'h500; reg_addr = 5'd20; reg_write = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_req", 32'(mem_req), 32'd0);
            check("hold_stall", 32'(mem_stall), 32'd0);
            check("hold_RegAddr", 32'(ra_o), 32'(e_ra));
            check("hold_ALUdata", alu_o, e_alu);
            @(posedge clk); #1;
        end
        clear_inputs();

        // Reset in the middle of a request
        mem_read = 2'd3; alu_data = 32'h600; reg_addr = 5'd21; reg_write = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        check("rst_mid_RegAddr", 32'(ra_o), 32'd0);
        clear_inputs();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        run_op(2'd3, 2'd0, 1'b1, 1'b0, 5'd22, 32'd0, 32'h700, 2, 32'h0BADF00D);

        // Randomized instructions
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rd, wr;
            rd = 2'($urandom_range(0, 3));
            wr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            run_op(rd, wr, 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                   $urandom, $urandom_range(0, 6), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
